// File: rtl/adf4350_spi_ctrl.sv
// ADF4350 synthesizer SPI master on the adcclk settings bus.
// One-deep pending buffer, drop counter and filtered MUXOUT lock detect.
module adf4350_spi_ctrl #(
   parameter logic [6:0] ADDR     = 7'd80,
   parameter int         CLK_DIV  = 4,
   parameter int         LOCK_CNT = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        serial_strobe,
   input  logic [6:0]  serial_addr,
   input  logic [31:0] serial_data,
   output logic        vco_sclk,
   output logic        vco_sdata,
   output logic        vco_le,
   input  logic        vco_muxout,
   output logic        busy,
   output logic        locked,
   output logic [31:0] status
);

   localparam logic [7:0]  DIV_TC  = 8'(CLK_DIV - 1);
   localparam logic [15:0] LOCK_TC = 16'(LOCK_CNT);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LE_SETUP,
      LE_HIGH
   } state_t;

   state_t      state;
   logic [31:0] shreg;
   logic [31:0] pend_word;
   logic        pending;
   logic [4:0]  bit_cnt;
   logic [7:0]  div;
   logic [7:0]  drop_cnt;
   logic        mux_s1;
   logic        mux_s2;
   logic [15:0] lock_cnt;
   logic        wr;
   logic        div_tc;

   assign wr     = serial_strobe && (serial_addr == ADDR);
   assign div_tc = (div == DIV_TC);
   assign busy   = (state != IDLE) | pending;
   assign locked = (lock_cnt == LOCK_TC);
   assign status = {16'd0, drop_cnt, 5'd0, pending, busy, locked};

   // SPI sequencer plus pending buffer; a pending word always wins in IDLE
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         pend_word <= '0;
         pending   <= 1'b0;
         bit_cnt   <= '0;
         div       <= '0;
         drop_cnt  <= '0;
         vco_sclk  <= 1'b0;
         vco_sdata <= 1'b0;
         vco_le    <= 1'b0;
      end else begin
         if (wr && state != IDLE) begin
            if (!pending) begin
               pend_word <= serial_data;
               pending   <= 1'b1;
            end else if (drop_cnt != 8'd255) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
         case (state)
            IDLE: begin
               div <= '0;
               if (pending) begin
                  shreg     <= pend_word;
                  vco_sdata <= pend_word[31];
                  bit_cnt   <= 5'd31;
                  state     <= SHIFT;
                  pending   <= wr;
                  if (wr) pend_word <= serial_data;
               end else if (wr) begin
                  shreg     <= serial_data;
                  vco_sdata <= serial_data[31];
                  bit_cnt   <= 5'd31;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_tc) begin
                  div      <= '0;
                  vco_sclk <= ~vco_sclk;
                  if (vco_sclk) begin
                     if (bit_cnt == 5'd0) begin
                        state <= LE_SETUP;
                     end else begin
                        shreg     <= shreg << 1;
                        vco_sdata <= shreg[30];
                        bit_cnt   <= bit_cnt - 5'd1;
                     end
                  end
               end else begin
                  div <= div + 8'd1;
               end
            end
            LE_SETUP: begin
               if (div_tc) begin
                  div    <= '0;
                  vco_le <= 1'b1;
                  state  <= LE_HIGH;
               end else begin
                  div <= div + 8'd1;
               end
            end
            LE_HIGH: begin
               if (div_tc) begin
                  div    <= '0;
                  vco_le <= 1'b0;
                  state  <= IDLE;
               end else begin
                  div <= div + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // bring the asynchronous MUXOUT into the adcclk domain
   always_ff @(posedge clock) begin
      if (reset) begin
         mux_s1 <= 1'b0;
         mux_s2 <= 1'b0;
      end else begin
         mux_s1 <= vco_muxout;
         mux_s2 <= mux_s1;
      end
   end

   // lock filter: count consecutive high samples, saturate, clear on any low
   always_ff @(posedge clock) begin
      if (reset) begin
         lock_cnt <= '0;
      end else if (mux_s2) begin
         if (lock_cnt != LOCK_TC) lock_cnt <= lock_cnt + 16'd1;
      end else begin
         lock_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_adf4350_spi_ctrl.sv
// Directed bench for adf4350_spi_ctrl.
// Cycle k is the clock period whose closing edge samples inputs driven in it.
module tb_adf4350_spi_ctrl;

   localparam logic [6:0] ADDR = 7'd80;
   localparam int         LK   = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        serial_strobe;
   logic [6:0]  serial_addr;
   logic [31:0] serial_data;
   logic        vco_sclk, vco_sdata, vco_le, busy, locked;
   logic        vco_muxout;
   logic [31:0] status;

   logic        strobe2;
   logic [31:0] data2;
   logic        sclk2, sdata2, le2, busy2, locked2;
   logic [31:0] status2;

   int checks = 0;
   int errors = 0;

   int          n_inj;
   int          inj_cyc [0:3];
   logic        inj_stb [0:3];
   logic [6:0]  inj_addr [0:3];
   logic [31:0] inj_data [0:3];

   int          rises, le_cnt, le_first, le_last, busy_low, busy_hi;
   logic        pend_hi;
   logic [63:0] cap;

   adf4350_spi_ctrl #(.ADDR(ADDR), .CLK_DIV(4), .LOCK_CNT(LK)) u_dut (
      .clock(clock), .reset(reset),
      .serial_strobe(serial_strobe), .serial_addr(serial_addr),
      .serial_data(serial_data),
      .vco_sclk(vco_sclk), .vco_sdata(vco_sdata), .vco_le(vco_le),
      .vco_muxout(vco_muxout),
      .busy(busy), .locked(locked), .status(status)
   );

   adf4350_spi_ctrl #(.ADDR(ADDR), .CLK_DIV(2), .LOCK_CNT(LK)) u_dut2 (
      .clock(clock), .reset(reset),
      .serial_strobe(strobe2), .serial_addr(ADDR),
      .serial_data(data2),
      .vco_sclk(sclk2), .vco_sdata(sdata2), .vco_le(le2),
      .vco_muxout(vco_muxout),
      .busy(busy2), .locked(locked2), .status(status2)
   );

   always #10 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // watch u_dut for ncyc cycles, driving the queued writes
   task automatic observe(input int ncyc);
      logic ps, pl;
      rises = 0; le_cnt = 0; le_first = -1; le_last = -1;
      busy_low = -1; busy_hi = 0; pend_hi = 1'b0; cap = '0;
      ps = 1'b0; pl = 1'b0;
      for (int k = 0; k <= ncyc; k++) begin
         @(negedge clock);
         if (k > 0) begin
            if (vco_sclk && !ps) begin
               rises++;
               cap = {cap[62:0], vco_sdata};
            end
            if (vco_le) begin
               if (!pl) le_cnt++;
               if (le_first < 0) le_first = k;
               le_last = k;
            end
            if (!busy && busy_low < 0) busy_low = k;
            if (busy) busy_hi++;
            if (status[2]) pend_hi = 1'b1;
         end
         ps = vco_sclk;
         pl = vco_le;
         serial_strobe = 1'b0;
         serial_addr   = ADDR;
         for (int i = 0; i < n_inj; i++) begin
            if (inj_cyc[i] == k) begin
               serial_strobe = inj_stb[i];
               serial_addr   = inj_addr[i];
               serial_data   = inj_data[i];
            end
         end
      end
      serial_strobe = 1'b0;
   endtask

   task automatic inj(input int i, input int c, input logic s,
                      input logic [6:0] a, input logic [31:0] d);
      inj_cyc[i]  = c;
      inj_stb[i]  = s;
      inj_addr[i] = a;
      inj_data[i] = d;
   endtask

   initial begin
      logic ps2, pl2;
      int   r2, l2, bl2, lk_rise, lk_fall, lk_re;
      logic [7:0] dmax;

      reset = 1'b1; serial_strobe = 1'b0; serial_addr = '0;
      serial_data = '0; vco_muxout = 1'b0; strobe2 = 1'b0; data2 = '0;
      n_inj = 0;
      repeat (3) @(negedge clock);
      check("rst_sclk", 64'(vco_sclk), 64'd0);
      check("rst_sdata", 64'(vco_sdata), 64'd0);
      check("rst_le", 64'(vco_le), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_locked", 64'(locked), 64'd0);
      check("rst_status", 64'(status), 64'd0);
      check("rst_status2", 64'(status2), 64'd0);
      reset = 1'b0;

      // 1: single word
      n_inj = 1;
      inj(0, 0, 1'b1, ADDR, 32'h0058_0005);
      observe(280);
      check("t1_rises", 64'(rises), 64'd32);
      check("t1_word", cap[31:0], 64'h0058_0005);
      check("t1_le_first", 64'(le_first), 64'd261);
      check("t1_le_last", 64'(le_last), 64'd264);
      check("t1_le_cnt", 64'(le_cnt), 64'd1);
      check("t1_busy_fall", 64'(busy_low), 64'd265);

      // 2: wrong address and strobe low
      n_inj = 2;
      inj(0, 0, 1'b1, 7'd79, 32'hFFFF_FFFF);
      inj(1, 2, 1'b0, ADDR, 32'hFFFF_FFFF);
      observe(30);
      check("t2_rises", 64'(rises), 64'd0);
      check("t2_busy", 64'(busy_hi), 64'd0);
      check("t2_status", 64'(status), 64'd0);

      // 3: A, B pending, C dropped
      n_inj = 3;
      inj(0, 0, 1'b1, ADDR, 32'hA5A5_0F0F);
      inj(1, 10, 1'b1, ADDR, 32'h1234_5678);
      inj(2, 20, 1'b1, ADDR, 32'hDEAD_BEEF);
      observe(560);
      check("t3_rises", 64'(rises), 64'd64);
      check("t3_words", cap, 64'hA5A5_0F0F_1234_5678);
      check("t3_le_cnt", 64'(le_cnt), 64'd2);
      check("t3_le_last", 64'(le_last), 64'd529);
      check("t3_busy_fall", 64'(busy_low), 64'd530);
      check("t3_pend_seen", 64'(pend_hi), 64'd1);
      check("t3_status", 64'(status), 64'h0000_0100);

      // 4: reset mid-transfer
      n_inj = 1;
      inj(0, 0, 1'b1, ADDR, 32'hFFFF_FFFF);
      observe(100);
      check("t4_busy_mid", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("t4_sclk", 64'(vco_sclk), 64'd0);
      check("t4_le", 64'(vco_le), 64'd0);
      check("t4_busy", 64'(busy), 64'd0);
      check("t4_status", 64'(status), 64'd0);
      n_inj = 0;
      observe(300);
      check("t4_no_le", 64'(le_cnt), 64'd0);
      check("t4_no_sclk", 64'(rises), 64'd0);
      n_inj = 1;
      inj(0, 0, 1'b1, ADDR, 32'h0C3C_5AA1);
      observe(280);
      check("t4_word", cap[31:0], 64'h0C3C_5AA1);
      check("t4_le_first", 64'(le_first), 64'd261);
      check("t4_busy_fall", 64'(busy_low), 64'd265);

      // 5: lock filter
      lk_rise = -1; lk_fall = -1; lk_re = -1;
      for (int k = 0; k <= 3 * LK + 20; k++) begin
         @(negedge clock);
         if (k > 0) begin
            if (locked && lk_rise < 0) lk_rise = k;
            if (!locked && lk_rise >= 0 && lk_fall < 0) lk_fall = k;
            if (locked && lk_fall >= 0 && lk_re < 0) lk_re = k;
            if (k == LK + 5) check("t5_status_lock", 64'(status), 64'd1);
         end
         vco_muxout = (k != LK + 10);
      end
      check("t5_rise", 64'(lk_rise), 64'(LK + 2));
      check("t5_fall", 64'(lk_fall), 64'(LK + 13));
      check("t5_rerise", 64'(lk_re), 64'(2 * LK + 13));
      vco_muxout = 1'b0;
      repeat (4) @(negedge clock);
      check("t5_unlock", 64'(locked), 64'd0);

      // 6: saturating drop counter on the CLK_DIV=2 instance
      r2 = 0; l2 = 0; bl2 = -1; ps2 = 1'b0; pl2 = 1'b0; dmax = '0;
      for (int k = 0; k <= 700; k++) begin
         @(negedge clock);
         if (k > 0) begin
            if (sclk2 && !ps2) r2++;
            if (le2 && !pl2) l2++;
            if (!busy2 && bl2 < 0) bl2 = k;
            if (status2[15:8] > dmax) dmax = status2[15:8];
         end
         ps2 = sclk2;
         pl2 = le2;
         strobe2 = (k < 300);
         data2   = 32'(k);
      end
      strobe2 = 1'b0;
      check("t6_drop", 64'(status2[15:8]), 64'd255);
      check("t6_drop_max", 64'(dmax), 64'd255);
      check("t6_words", 64'(l2), 64'd4);
      check("t6_rises", 64'(r2), 64'd128);
      check("t6_busy_fall", 64'(bl2), 64'd532);
      check("t6_pending", 64'(status2[2]), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
